// File: rtl/hash_freq_reader_pkg.sv
// Shared constants, state encoding and helpers for the hash/occurrence table
// reader. The hash builder uses the same table geometry and read latency.
package hash_freq_reader_pkg;

    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEPTH         = 128;
    localparam int ADDR_BITS     = log2(DEPTH);
    localparam int MASK          = DEPTH - 1;
    localparam int DATA_BITS     = 32;
    // Registered-address dual table: data shows up two cycles after RdAddr.
    localparam int READ_LATENCY  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        EMIT,
        CLEAR,
        NEXT,
        DONE
    } reader_state_t;

endpackage

// File: rtl/hash_freq_reader.sv
// Scans every slot of the hash/occurrence table and streams entries whose
// count reaches the threshold as (value, count, slot) records, optionally zeroing slots.
module hash_freq_reader
    import hash_freq_reader_pkg::*;
#(
    parameter int BIT_ON_TAILS     = ADDR_BITS,
    parameter int DATA_INDEX_WIDTH = DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        clear_en,
    input  logic [DATA_INDEX_WIDTH-1:0] threshold,
    output logic                        busy,
    output logic                        done,
    output logic [BIT_ON_TAILS-1:0]     RdAddr,
    input  logic [DATA_INDEX_WIDTH-1:0] HashValue,
    input  logic [DATA_INDEX_WIDTH-1:0] OccurrValue,
    output logic                        WrEn,
    output logic [BIT_ON_TAILS-1:0]     WrAddr,
    output logic [DATA_INDEX_WIDTH-1:0] NewHashValue,
    output logic [DATA_INDEX_WIDTH-1:0] NewOccurrValue,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_INDEX_WIDTH-1:0] out_value,
    output logic [DATA_INDEX_WIDTH-1:0] out_count,
    output logic [BIT_ON_TAILS-1:0]     out_slot,
    output logic [BIT_ON_TAILS:0]       emit_count,
    output logic [DATA_INDEX_WIDTH-1:0] total_occurr
);

    localparam logic [BIT_ON_TAILS-1:0] LAST_ADDR = BIT_ON_TAILS'((1 << BIT_ON_TAILS) - 1);

    reader_state_t                 state, next_state;
    logic [BIT_ON_TAILS-1:0]       addr;
    logic                          clear_q;
    logic [DATA_INDEX_WIDTH-1:0]   thr_q;
    logic [DATA_INDEX_WIDTH:0]     sum_wide;
    logic [DATA_INDEX_WIDTH-1:0]   sat_sum;

    assign RdAddr         = addr;
    assign WrAddr         = addr;
    assign NewHashValue   = '0;
    assign NewOccurrValue = '0;

    assign sum_wide = {1'b0, total_occurr} + {1'b0, out_count};
    assign sat_sum  = sum_wide[DATA_INDEX_WIDTH] ? '1 : sum_wide[DATA_INDEX_WIDTH-1:0];

    // The threshold is forced to at least 1 when latched, so a zero count can never qualify.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = CAPTURE;
            CAPTURE: begin
                if (OccurrValue >= thr_q) next_state = EMIT;
                else if (clear_q)         next_state = CLEAR;
                else                      next_state = NEXT;
            end
            EMIT:    if (out_ready) next_state = clear_q ? CLEAR : NEXT;
            CLEAR:   next_state = NEXT;
            NEXT:    next_state = (addr == LAST_ADDR) ? DONE : ISSUE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status strobes are decoded from next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            clear_q      <= 1'b0;
            thr_q        <= DATA_INDEX_WIDTH'(1);
            busy         <= 1'b0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
            WrEn         <= 1'b0;
            out_value    <= '0;
            out_count    <= '0;
            out_slot     <= '0;
            emit_count   <= '0;
            total_occurr <= '0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != IDLE) && (next_state != DONE);
            done      <= (next_state == DONE);
            out_valid <= (next_state == EMIT);
            WrEn      <= (next_state == CLEAR);
            case (state)
                IDLE: begin
                    if (start) begin
                        thr_q        <= (threshold == '0) ? DATA_INDEX_WIDTH'(1) : threshold;
                        clear_q      <= clear_en;
                        addr         <= '0;
                        emit_count   <= '0;
                        total_occurr <= '0;
                    end
                end
                CAPTURE: begin
                    out_value <= HashValue;
                    out_count <= OccurrValue;
                    out_slot  <= addr;
                end
                EMIT: begin
                    if (out_ready) begin
                        emit_count   <= emit_count + (BIT_ON_TAILS + 1)'(1);
                        total_occurr <= sat_sum;
                    end
                end
                NEXT: begin
                    if (addr != LAST_ADDR) addr <= addr + BIT_ON_TAILS'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
